// File: rtl/sa_result_drain.sv
// sa_result_drain: bottom-edge reader for the systolic array.
// Samples the skewed out_bot column streams, re-aligns them into result rows,
// buffers the rows in a small FIFO and offers them downstream on valid/ready.
// Optional macro SA_DRAIN_RELU_EN: lanes with MSB set are stored as zero.
module sa_result_drain #(
    parameter int DIMENSION    = 4,
    parameter int OUT_WIDTH    = 14,
    parameter int PIPE_LATENCY = 4,
    parameter int ROWS         = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [OUT_WIDTH-1:0]           out_bot [DIMENSION],
    output logic [DIMENSION*OUT_WIDTH-1:0] res_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    localparam int ROW_W     = DIMENSION * OUT_WIDTH;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int CAP_EDGES = ROWS + DIMENSION - 1;
    localparam int SEQ_W     = $clog2(CAP_EDGES + PIPE_LATENCY + 1);

    localparam logic [SEQ_W-1:0] WAIT_LAST  = SEQ_W'((PIPE_LATENCY >= 2) ? PIPE_LATENCY - 2 : 0);
    localparam logic [SEQ_W-1:0] CAP_LAST   = SEQ_W'(CAP_EDGES - 1);
    localparam logic [SEQ_W-1:0] PUSH_FIRST = SEQ_W'(DIMENSION - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic [ROW_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ROW_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 drop;
    logic                 start_acc;
    logic                 shift_en;
    logic [OUT_WIDTH-1:0] lane_raw [DIMENSION];
    logic [ROW_W-1:0]     row_wr;

    assign shift_en  = (state_q != S_IDLE);
    assign start_acc = (state_q == S_IDLE) && start;

    // Column j needs DIMENSION-1-j delay stages so every lane of a row lines up
    // with the last column; the last column is taken straight from the array.
    genvar j;
    generate
        for (j = 0; j < DIMENSION; j++) begin : g_lane
            if (j == DIMENSION - 1) begin : g_direct
                assign lane_raw[j] = out_bot[j];
            end else begin : g_skew
                localparam int STAGES = DIMENSION - 1 - j;
                logic [OUT_WIDTH-1:0] skew_q [STAGES];
                logic [OUT_WIDTH-1:0] skew_d [STAGES];

                // Shift the column sample down its delay line while a tile is active
                always_comb begin
                    skew_d[0] = shift_en ? out_bot[j] : skew_q[0];
                    for (int s = 1; s < STAGES; s++) begin
                        skew_d[s] = shift_en ? skew_q[s-1] : skew_q[s];
                    end
                end

                // Delay-line registers
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        for (int s = 0; s < STAGES; s++) begin
                            skew_q[s] <= '0;
                        end
                    end else begin
                        for (int s = 0; s < STAGES; s++) begin
                            skew_q[s] <= skew_d[s];
                        end
                    end
                end

                assign lane_raw[j] = skew_q[STAGES-1];
            end
        end
    endgenerate

    // Pack the aligned lanes into the row written to the FIFO
    always_comb begin
        row_wr = '0;
        for (int l = 0; l < DIMENSION; l++) begin
`ifdef SA_DRAIN_RELU_EN
            row_wr[l*OUT_WIDTH +: OUT_WIDTH] = lane_raw[l][OUT_WIDTH-1] ? '0 : lane_raw[l];
`else
            row_wr[l*OUT_WIDTH +: OUT_WIDTH] = lane_raw[l];
`endif
        end
    end

    // Tile sequencer: wait out the array latency, capture, then drain the FIFO
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        done_d   = 1'b0;
        push_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    seq_d   = '0;
                    state_d = (PIPE_LATENCY == 1) ? S_CAPTURE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (seq_q == WAIT_LAST) begin
                    seq_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                push_req = (seq_q >= PUSH_FIRST);
                if (seq_q == CAP_LAST) begin
                    seq_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    seq_d = seq_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Row FIFO: a push into a full FIFO only succeeds when a pop frees a slot
    // on the same edge; otherwise the row is lost because the array cannot stall.
    always_comb begin
        pop        = res_valid && res_ready;
        full       = (count_q == FULL_CNT);
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = start_acc ? 1'b0 : (overflow_q || drop);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = row_wr;
        end
    end

    // State, FIFO and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            seq_q      <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign res_valid = (count_q != '0);
    assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule
